// File: rtl/image_rotator_if.sv
// Pixel stream bundle for the image rotator: an input stream into the
// frame buffer and an output stream with row-end/last markers.
// The block uses the slave modport; the pixel source/sink uses master.
interface image_rotator_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_ready;
  logic             out_row_end;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row_end, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row_end, out_last
  );
endinterface

// File: rtl/image_rotator.sv
// Single-frame buffer rotator: loads one IMG_W x IMG_H frame in raster
// order, then streams it out rotated by 0/90/180/270 degrees clockwise.
// Reads go through a 1-cycle RAM into a 2-entry skid so the output side
// can stall at any time without losing or repeating pixels.
// Optional feature: define IMGROT_MIRROR_EN to add the 'mirror' port,
// which reverses every output row after rotation.
module image_rotator #(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 1024,
  parameter int PIX_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  image_rotator_if.slave bus,
  input  logic       start,
  input  logic [1:0] rot,
`ifdef IMGROT_MIRROR_EN
  input  logic       mirror,
`endif
  output logic       loaded,
  output logic       frame_done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int DMAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW   = $clog2(DMAX);
  localparam int EW   = PIX_W + 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [PIX_W-1:0] mem [NPIX];
  logic [AW-1:0]    wr_cnt;
  logic [1:0]       rot_q;
  logic             mirror_q;
  logic [CW-1:0]    row_i, col_j, col_m, ow_last, oh_last, src_r, src_c;
  logic             gen_done, issue, wr_fire, start_fire, pop, last_pop;
  logic             row_end_now, last_now;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic             rd_pend, rd_row_end, rd_last;
  logic [EW-1:0]    rd_entry, sk0, sk1;
  logic [1:0]       sk_cnt;

  assign wr_fire     = bus.in_valid && bus.in_ready;
  assign start_fire  = (state == S_WAIT) && start;
  assign pop         = bus.out_valid && bus.out_ready;
  assign last_pop    = pop && sk0[0];
  assign ow_last     = rot_q[0] ? CW'(IMG_H - 1) : CW'(IMG_W - 1);
  assign oh_last     = rot_q[0] ? CW'(IMG_W - 1) : CW'(IMG_H - 1);
  assign col_m       = mirror_q ? (ow_last - col_j) : col_j;
  assign row_end_now = (col_j == ow_last);
  assign last_now    = row_end_now && (row_i == oh_last);
  assign issue       = (state == S_DRAIN) && !gen_done &&
                       (({1'b0, sk_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));

  assign bus.in_ready    = (state == S_LOAD) && rst;
  assign loaded          = (state == S_WAIT);
  assign bus.out_valid   = (sk_cnt != 2'd0);
  assign bus.out_data    = sk0[EW-1:2];
  assign bus.out_row_end = sk0[1] && bus.out_valid;
  assign bus.out_last    = sk0[0] && bus.out_valid;
  assign rd_entry        = {rd_data, rd_row_end, rd_last};
  assign rd_addr         = AW'(src_r * IMG_W) + AW'(src_c);

`ifndef IMGROT_MIRROR_EN
  assign mirror_q = 1'b0;
`endif

  // Map the output (row, col) position back to its source pixel
  always_comb begin
    src_r = '0;
    src_c = '0;
    case (rot_q)
      2'd0: begin
        src_r = row_i;
        src_c = col_m;
      end
      2'd1: begin
        src_r = CW'(IMG_H - 1) - col_m;
        src_c = row_i;
      end
      2'd2: begin
        src_r = CW'(IMG_H - 1) - row_i;
        src_c = CW'(IMG_W - 1) - col_m;
      end
      default: begin
        src_r = col_m;
        src_c = CW'(IMG_W - 1) - row_i;
      end
    endcase
  end

  // Frame RAM: raster-order writes during load, registered reads while draining
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_cnt] <= bus.in_data;
    if (issue) rd_data <= mem[rd_addr];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  end

  // Next-state: load a full frame, wait for start, drain until last pixel leaves
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (wr_fire && wr_cnt == LAST_ADDR) state_nxt = S_WAIT;
      S_WAIT:  if (start) state_nxt = S_DRAIN;
      S_DRAIN: if (last_pop) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Counters, address generator, read pipeline and output skid
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt     <= '0;
      rot_q      <= '0;
      row_i      <= '0;
      col_j      <= '0;
      gen_done   <= 1'b0;
      rd_pend    <= 1'b0;
      rd_row_end <= 1'b0;
      rd_last    <= 1'b0;
      sk0        <= '0;
      sk1        <= '0;
      sk_cnt     <= 2'd0;
      frame_done <= 1'b0;
`ifdef IMGROT_MIRROR_EN
      mirror_q   <= 1'b0;
`endif
    end else begin
      if (wr_fire) wr_cnt <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + 1'b1;

      if (start_fire) begin
        rot_q    <= rot;
`ifdef IMGROT_MIRROR_EN
        mirror_q <= mirror;
`endif
        row_i    <= '0;
        col_j    <= '0;
        gen_done <= 1'b0;
      end else if (issue) begin
        if (row_end_now) begin
          col_j <= '0;
          if (row_i == oh_last) gen_done <= 1'b1;
          else                  row_i <= row_i + 1'b1;
        end else begin
          col_j <= col_j + 1'b1;
        end
      end

      rd_pend    <= issue;
      rd_row_end <= issue && row_end_now;
      rd_last    <= issue && last_now;

      case ({rd_pend, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) sk0 <= rd_entry;
          else                sk1 <= rd_entry;
          sk_cnt <= sk_cnt + 1'b1;
        end
        2'b01: begin
          sk0    <= sk1;
          sk_cnt <= sk_cnt - 1'b1;
        end
        2'b11: begin
          if (sk_cnt == 2'd1) begin
            sk0 <= rd_entry;
          end else begin
            sk0 <= sk1;
            sk1 <= rd_entry;
          end
        end
        default: ;
      endcase

      frame_done <= last_pop;
    end
  end
endmodule

// File: tb/tb_image_rotator.sv
// Self-checking bench for image_rotator on a 4x3 frame of 8-bit pixels.
// Expected output is built by rotating a copy of the loaded frame in 90
// degree steps and queued at start; a monitor pops and compares on every
// output handshake. Define IMGROT_MIRROR_EN to cover the mirror option.
module tb_image_rotator;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DM = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       row_end;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rot = 2'd0;
  logic       loaded;
  logic       frame_done;
`ifdef IMGROT_MIRROR_EN
  logic       mirror_drv = 1'b0;
`endif

  int         errors = 0;
  int         checks = 0;
  int         pop_count = 0;
  exp_t       exp_q[$];
  logic [7:0] src [W*H];

  image_rotator_if #(.PIX_W(8)) bus ();

  image_rotator #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .start      (start),
    .rot        (rot),
`ifdef IMGROT_MIRROR_EN
    .mirror     (mirror_drv),
`endif
    .loaded     (loaded),
    .frame_done (frame_done)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Output monitor: compare each handshake against the scoreboard, check hold during stalls
  task automatic monitor_loop();
    exp_t e;
    bit   hold = 1'b0;
    exp_t held;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== held.data ||
              bus.out_row_end !== held.row_end || bus.out_last !== held.last) begin
            errors++;
            $display("[TB] FAIL stall_hold: got v=%b d=%h re=%b l=%b, need v=1 d=%h re=%b l=%b",
                     bus.out_valid, bus.out_data, bus.out_row_end, bus.out_last,
                     held.data, held.row_end, held.last);
          end
        end
        hold = 1'b0;
        if (bus.out_valid === 1'b1) begin
          if (bus.out_ready) begin
            checks++;
            pop_count++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("[TB] FAIL unexpected_pixel: got d=%h, need no output", bus.out_data);
            end else begin
              e = exp_q.pop_front();
              if (bus.out_data !== e.data || bus.out_row_end !== e.row_end ||
                  bus.out_last !== e.last) begin
                errors++;
                $display("[TB] FAIL pixel: got d=%h re=%b l=%b, need d=%h re=%b l=%b",
                         bus.out_data, bus.out_row_end, bus.out_last, e.data, e.row_end, e.last);
              end
            end
          end else begin
            hold = 1'b1;
            held.data    = bus.out_data;
            held.row_end = bus.out_row_end;
            held.last    = bus.out_last;
          end
        end
      end
    end
  endtask

  // Feed pixels first..first+count-1 of a frame whose pixel k is base+k
  task automatic applyStimulus(input int first, input int count, input logic [7:0] base);
    int guard;
    for (int k = first; k < first + count; k++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = base + 8'(k);
      src[k]       = base + 8'(k);
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Build the expected rotated frame from src and queue it
  task automatic push_expected(input int r, input bit m);
    logic [7:0] cur [DM][DM];
    logic [7:0] nxt [DM][DM];
    int h, w, t;
    exp_t e;
    h = H;
    w = W;
    for (int rr = 0; rr < DM; rr++)
      for (int cc = 0; cc < DM; cc++) begin
        cur[rr][cc] = 8'h00;
        nxt[rr][cc] = 8'h00;
      end
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        cur[rr][cc] = src[rr*W + cc];
    for (int n = 0; n < r; n++) begin
      for (int rr = 0; rr < w; rr++)
        for (int cc = 0; cc < h; cc++)
          nxt[rr][cc] = cur[h-1-cc][rr];
      t = h; h = w; w = t;
      cur = nxt;
    end
    for (int rr = 0; rr < h; rr++)
      for (int cc = 0; cc < w; cc++) begin
        e.data    = m ? cur[rr][w-1-cc] : cur[rr][cc];
        e.row_end = (cc == w - 1);
        e.last    = (cc == w - 1) && (rr == h - 1);
        exp_q.push_back(e);
      end
  endtask

  // One-cycle start pulse with the requested rotation
  task automatic pulse_start(input logic [1:0] r);
    @(posedge clk); #1;
    start = 1'b1;
    rot   = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive out_ready until the scoreboard empties; report frame-end observations
  task automatic run_drain(input bit rnd, input int budget, output bit timed_out,
                           output int cycles, output logic fd1, output logic fd2,
                           output logic ir);
    int stall_left;
    stall_left = 0;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (rnd) begin
        if (cycles == 3 || cycles == 14) stall_left = 5;
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    timed_out = (exp_q.size() != 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    fd1 = frame_done;
    ir  = bus.in_ready;
    @(negedge clk);
    fd2 = frame_done;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, loaded, bus.out_valid, bus.out_data, bus.out_row_end,
         bus.out_last, frame_done} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ir=%b ld=%b v=%b d=%h re=%b l=%b fd=%b, need all 0",
               bus.in_ready, loaded, bus.out_valid, bus.out_data, bus.out_row_end,
               bus.out_last, frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_in_ready: got %b, need 1", bus.in_ready);
    end
  endtask

  task automatic test_rot1();
    bit   to;
    int   cyc;
    logic fd1, fd2, ir;
    applyStimulus(0, W*H, 8'h00);
    @(negedge clk);
    checks++;
    if (loaded !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rot1_loaded: got ld=%b ir=%b, need ld=1 ir=0", loaded, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    push_expected(1, 1'b0);
    pulse_start(2'd1);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rot1_latency_n0: got v=%b ld=%b, need v=0 ld=0", bus.out_valid, loaded);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rot1_latency_n1: got v=%b, need 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rot1_latency_n2: got v=%b, need 1", bus.out_valid);
    end
    run_drain(1'b0, 200, to, cyc, fd1, fd2, ir);
    checks++;
    if (to || cyc != W*H) begin
      errors++;
      $display("[TB] FAIL rot1_throughput: got cycles=%0d timeout=%b, need cycles=%0d timeout=0",
               cyc, to, W*H);
    end
    checks++;
    if (fd1 !== 1'b1 || fd2 !== 1'b0 || ir !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rot1_frame_done: got fd=%b,%b ir=%b, need fd=1,0 ir=1", fd1, fd2, ir);
    end
  endtask

  task automatic test_rot_other();
    bit   to;
    int   cyc;
    logic fd1, fd2, ir;
    int   rots [2];
    rots[0] = 2;
    rots[1] = 3;
    for (int n = 0; n < 2; n++) begin
      applyStimulus(0, W*H, 8'h00);
      push_expected(rots[n], 1'b0);
      pulse_start(2'(rots[n]));
      run_drain(1'b0, 200, to, cyc, fd1, fd2, ir);
      checks++;
      if (to || fd1 !== 1'b1 || fd2 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rot%0d_frame_end: got timeout=%b fd=%b,%b, need timeout=0 fd=1,0",
                 rots[n], to, fd1, fd2);
      end
    end
  endtask

  task automatic test_stall();
    bit   to;
    int   cyc;
    logic fd1, fd2, ir;
    applyStimulus(0, W*H, 8'h00);
    bus.out_ready = 1'b0;
    push_expected(1, 1'b0);
    pulse_start(2'd1);
    run_drain(1'b1, 400, to, cyc, fd1, fd2, ir);
    checks++;
    if (to || fd1 !== 1'b1 || fd2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_frame_end: got timeout=%b fd=%b,%b, need timeout=0 fd=1,0",
               to, fd1, fd2);
    end
  endtask

  task automatic test_start_in_load();
    bit   to;
    int   cyc;
    logic fd1, fd2, ir;
    applyStimulus(0, 5, 8'h00);
    pulse_start(2'd0);
    applyStimulus(5, 6, 8'h00);
    @(negedge clk);
    checks++;
    if (loaded !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_in_load_early: got ld=%b v=%b after 11 pixels, need ld=0 v=0",
               loaded, bus.out_valid);
    end
    applyStimulus(11, 1, 8'h00);
    @(negedge clk);
    checks++;
    if (loaded !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_load_loaded: got ld=%b after 12 pixels, need 1", loaded);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_load_idle: got v=%b ld=%b, need v=0 ld=1", bus.out_valid, loaded);
    end
    push_expected(0, 1'b0);
    pulse_start(2'd0);
    run_drain(1'b0, 200, to, cyc, fd1, fd2, ir);
    checks++;
    if (to || fd1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rot0_frame_end: got timeout=%b fd=%b, need timeout=0 fd=1", to, fd1);
    end
  endtask

  task automatic test_in_valid_drain();
    bit   to;
    int   cyc;
    logic fd1, fd2, ir;
    logic ir_seen;
    ir_seen = 1'b0;
    applyStimulus(0, W*H, 8'h80);
    push_expected(2, 1'b0);
    pulse_start(2'd2);
    fork
      run_drain(1'b0, 200, to, cyc, fd1, fd2, ir);
      begin
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          bus.in_valid = 1'b1;
          bus.in_data  = 8'hFF;
          @(negedge clk);
          if (bus.in_ready !== 1'b0) ir_seen = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
    join
    checks++;
    if (to || ir_seen || fd1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL in_valid_drain: got timeout=%b in_ready_seen=%b fd=%b, need 0 0 1",
               to, ir_seen, fd1);
    end
    applyStimulus(0, W*H, 8'h40);
    push_expected(1, 1'b0);
    pulse_start(2'd1);
    run_drain(1'b0, 200, to, cyc, fd1, fd2, ir);
    checks++;
    if (to || fd1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL next_frame_after_drain: got timeout=%b fd=%b, need 0 1", to, fd1);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit   to;
    int   cyc;
    int   base_pops;
    int   guard;
    logic fd1, fd2, ir;
    applyStimulus(0, W*H, 8'h00);
    bus.out_ready = 1'b1;
    push_expected(1, 1'b0);
    base_pops = pop_count;
    pulse_start(2'd1);
    guard = 0;
    while (pop_count - base_pops < 6 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    rst = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || loaded !== 1'b0 ||
        pop_count - base_pops != 6) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain: got v=%b ir=%b ld=%b pops=%0d, need v=0 ir=1 ld=0 pops=6",
               bus.out_valid, bus.in_ready, loaded, pop_count - base_pops);
    end
    applyStimulus(0, W*H, 8'h60);
    push_expected(3, 1'b0);
    pulse_start(2'd3);
    run_drain(1'b0, 200, to, cyc, fd1, fd2, ir);
    checks++;
    if (to || fd1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_reset_frame: got timeout=%b fd=%b, need 0 1", to, fd1);
    end
  endtask

`ifdef IMGROT_MIRROR_EN
  task automatic test_mirror();
    bit   to;
    int   cyc;
    logic fd1, fd2, ir;
    applyStimulus(0, W*H, 8'h00);
    push_expected(0, 1'b1);
    mirror_drv = 1'b1;
    pulse_start(2'd0);
    mirror_drv = 1'b0;
    run_drain(1'b0, 200, to, cyc, fd1, fd2, ir);
    checks++;
    if (to || fd1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mirror_frame_end: got timeout=%b fd=%b, need 0 1", to, fd1);
    end
  endtask
`endif

  // Test sequence
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    for (int k = 0; k < W*H; k++) src[k] = 8'h00;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_rot1();
    test_rot_other();
    test_stall();
    test_start_in_load();
    test_in_valid_drain();
    test_reset_mid_drain();
`ifdef IMGROT_MIRROR_EN
    test_mirror();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
